// File: rtl/dmem_access_unit.sv
// ============================================================================
// dmem_access_unit
//
// Purpose:
//   This is the MEM-stage initiator toward the data memory port. It takes one
//   load or store per pipeline slot from the EX/MEM register and issues a
//   word-aligned request. It builds the byte-lane write mask and the shifted
//   store data. The pipeline is stalled until dmem_resp arrives. After that,
//   the raw read word is presented for the MEM/WB register. Sign or zero
//   extension is done downstream.
//
//   State table:
//     state | meaning
//     ------+-----------------------------------------------------------
//     IDLE  | no access in flight; decode request, accept or flag error
//     BUSY  | strobe asserted, waiting for dmem_resp (or timeout)
//     DONE  | access complete; pipeline advances, request inputs ignored
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   req_valid/read/write        EX/MEM memory-instruction qualifiers
//   funct3                      RV32I width code (b, h, w, bu, hu)
//   addr, store_data            effective address and forwarded rs2
//   dmem_address/read/write     word-aligned memory request and strobes
//   dmem_wmask, dmem_wdata      byte enables and lane-aligned store data
//   dmem_resp, dmem_rdata       memory completion and read word
//   rdata_out                   latched raw read word of last load
//   stall_out                   freeze IF..MEM pipeline registers
//   done                        one-cycle pulse when an access completes
//   req_error                   one-cycle pulse: misaligned/illegal/timeout
// ============================================================================
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata_out,
    output logic        stall_out,
    output logic        done,
    output logic        req_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before the access is abandoned. When the timeout
    // is disabled this value is unused, so 0 keeps the constant in range.
    localparam int              TC_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TC_LAST  = TC_LAST_I[CNT_W-1:0];

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       addr_nxt;
    logic              rd_nxt, wr_nxt;
    logic [3:0]        mask_nxt;
    logic [31:0]       wdata_nxt;
    logic [31:0]       rdata_nxt;
    logic              err_nxt;

    logic              is_b, is_h, is_w, f3_ok, op_one;
    logic              misaligned, legal_go, bad_req;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;

    // Request decode and lane generation
    always_comb begin
        is_b       = (funct3 == 3'b000) || (funct3 == 3'b100);
        is_h       = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_w       = (funct3 == 3'b010);
        f3_ok      = is_b || is_h || is_w;
        op_one     = req_read ^ req_write;
        misaligned = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
        legal_go   = req_valid && op_one && f3_ok && !misaligned;
        bad_req    = req_valid && ((req_read && req_write) || !f3_ok
                                   || (op_one && misaligned));

        lane_mask = 4'b1111;
        lane_data = store_data;
        if (is_b) begin
            lane_mask = 4'b0001 << addr[1:0];
            lane_data = {24'h0, store_data[7:0]} << {addr[1:0], 3'b000};
        end else if (is_h) begin
            lane_mask = 4'b0011 << {addr[1], 1'b0};
            lane_data = {16'h0, store_data[15:0]} << {addr[1], 4'b0000};
        end
        // Loads drive no byte enables and no data.
        if (req_read) begin
            lane_mask = 4'b0000;
            lane_data = 32'h0;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = dmem_address;
        rd_nxt    = dmem_read;
        wr_nxt    = dmem_write;
        mask_nxt  = dmem_wmask;
        wdata_nxt = dmem_wdata;
        rdata_nxt = rdata_out;
        err_nxt   = 1'b0;
        stall_out = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                stall_out = legal_go;
                if (legal_go) begin
                    addr_nxt  = {addr[31:2], 2'b00};
                    rd_nxt    = req_read;
                    wr_nxt    = req_write;
                    mask_nxt  = lane_mask;
                    wdata_nxt = lane_data;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end else if (bad_req) begin
                    err_nxt = 1'b1;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                if (dmem_resp) begin
                    // The held read strobe identifies a load, so stores keep
                    // the previous read word.
                    if (dmem_read) begin
                        rdata_nxt = dmem_rdata;
                    end
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt == TC_LAST)) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dmem_address <= 32'h0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 4'h0;
            dmem_wdata   <= 32'h0;
            rdata_out    <= 32'h0;
            req_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            dmem_address <= addr_nxt;
            dmem_read    <= rd_nxt;
            dmem_write   <= wr_nxt;
            dmem_wmask   <= mask_nxt;
            dmem_wdata   <= wdata_nxt;
            rdata_out    <= rdata_nxt;
            req_error    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// tb_dmem_access_unit
//
// Purpose:
//   Directed bench for dmem_access_unit. Completion and error pulses are
//   checked by a monitor against a queue of expected events. Request-side
//   outputs are checked inline by the stimulus tasks.
// Ports: none (top-level bench).
// ============================================================================
module tb_dmem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic [31:0] rdata_out;
    logic        stall_out;
    logic        done;
    logic        req_error;

    dmem_access_unit #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_read    (req_read),
        .req_write   (req_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .dmem_address(dmem_address),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_resp   (dmem_resp),
        .dmem_rdata  (dmem_rdata),
        .rdata_out   (rdata_out),
        .stall_out   (stall_out),
        .done        (done),
        .req_error   (req_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [31:0] hold_rdata = 32'h0;
    int   acc_cyc;
    int   done_cyc;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: every done or req_error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (done || req_error)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {126'h0, done, req_error}, 128'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("event_kind", {126'h0, done, req_error},
                    {126'h0, !e.is_err, e.is_err});
                if (!e.is_err) chk("rdata_out", {96'h0, rdata_out}, {96'h0, e.rdata});
            end
        end
    end

    // Legal access with the response in the nbusy-th BUSY cycle. The request
    // stays on the inputs through DONE, as a stalled pipeline would hold it.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int nbusy, input logic [31:0] rdat,
                          input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata);
        exp_t e;
        int rd_n = 0, wr_n = 0, st_n = 0;
        if (rd) hold_rdata = rdat;
        e.is_err = 1'b0;
        e.rdata  = hold_rdata;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_read = rd; req_write = wr;
        funct3 = f3; addr = a; store_data = sd; dmem_resp = 1'b0;
        @(negedge clk);
        acc_cyc = cyc;
        chk("stall_accept", {127'h0, stall_out}, 128'h1);
        st_n = 1;
        for (int i = 0; i < nbusy; i++) begin
            @(posedge clk); #1;
            if (i == nbusy - 1) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdat;
            end
            @(negedge clk);
            if (dmem_read)  rd_n++;
            if (dmem_write) wr_n++;
            if (stall_out)  st_n++;
            if (i == 0) begin
                chk("dmem_address", {96'h0, dmem_address}, {96'h0, exp_addr});
                chk("dmem_wmask",   {124'h0, dmem_wmask},  {124'h0, exp_mask});
                chk("dmem_wdata",   {96'h0, dmem_wdata},   {96'h0, exp_wdata});
            end
        end
        @(posedge clk); #1;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        done_cyc = cyc;
        chk("done_cycle_quiet", {125'h0, dmem_read, dmem_write, stall_out}, 128'h0);
        chk("read_cycles",  128'(rd_n), rd ? 128'(nbusy) : 128'h0);
        chk("write_cycles", 128'(wr_n), wr ? 128'(nbusy) : 128'h0);
        chk("stall_cycles", 128'(st_n), 128'(nbusy + 1));
    endtask

    task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a);
        exp_t e;
        e.is_err = 1'b1;
        e.rdata  = 32'h0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_read = rd; req_write = wr;
        funct3 = f3; addr = a; store_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("bad_no_stall", {125'h0, dmem_read, dmem_write, stall_out}, 128'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bad_no_strobe", {125'h0, dmem_read, dmem_write, stall_out}, 128'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; dmem_resp = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first_acc;
        int n_rd;
        rst = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        funct3 = 3'b010; addr = 32'h0; store_data = 32'h0;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;

        // Reset state, including a stray response while in reset/idle
        @(negedge clk);
        chk("reset_outputs", {23'h0, dmem_address, dmem_read, dmem_write, dmem_wmask,
            dmem_wdata, rdata_out, stall_out, done, req_error}, 128'h0);
        rst = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("idle_resp_ignored", {93'h0, rdata_out, done, stall_out, dmem_read},
            128'h0);
        idle(2);

        // lw 0x1008, 3 BUSY cycles
        access(1'b1, 1'b0, 3'b010, 32'h0000_1008, 32'h0, 3, 32'hDEAD_BEEF,
               32'h0000_1008, 4'b0000, 32'h0);
        idle(1);
        // sb 0x2003
        access(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 1, 32'h5555_AAAA,
               32'h0000_2000, 4'b1000, 32'hA500_0000);
        // sh 0x2002
        access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 2, 32'h5555_AAAA,
               32'h0000_2000, 4'b1100, 32'h1234_0000);
        // sw 0x3004
        access(1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 1, 32'h5555_AAAA,
               32'h0000_3004, 4'b1111, 32'hCAFE_F00D);
        // sb 0x2001, upper bits of rs2 must be discarded
        access(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'hFFFF_FF5A, 1, 32'h5555_AAAA,
               32'h0000_2000, 4'b0010, 32'h0000_5A00);
        // sh 0x2000, low half lane
        access(1'b0, 1'b1, 3'b101, 32'h0000_2000, 32'hABCD_8765, 1, 32'h5555_AAAA,
               32'h0000_2000, 4'b0011, 32'h0000_8765);
        // lbu 0x4002
        access(1'b1, 1'b0, 3'b100, 32'h0000_4002, 32'hFFFF_FFFF, 2, 32'h1122_3344,
               32'h0000_4000, 4'b0000, 32'h0);
        idle(1);

        // Misaligned and illegal requests
        bad_access(1'b1, 1'b0, 3'b010, 32'h0000_1001);
        bad_access(1'b1, 1'b0, 3'b001, 32'h0000_1003);
        bad_access(1'b0, 1'b1, 3'b011, 32'h0000_1000);
        bad_access(1'b1, 1'b1, 3'b010, 32'h0000_1000);
        idle(1);

        // Back-to-back loads, 1 BUSY cycle each: 6 cycles total
        access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1, 32'hA1A1_A1A1,
               32'h0000_0010, 4'b0000, 32'h0);
        first_acc = acc_cyc;
        access(1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0, 1, 32'hB2B2_B2B2,
               32'h0000_0014, 4'b0000, 32'h0);
        chk("b2b_total_cycles", 128'(done_cyc - first_acc + 1), 128'd6);
        idle(1);

        // Timeout: no response, 4 BUSY cycles then req_error
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.rdata  = 32'h0;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        funct3 = 3'b010; addr = 32'h0000_6000;
        @(negedge clk);
        chk("timeout_stall_accept", {127'h0, stall_out}, 128'h1);
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            if (dmem_read) n_rd++;
            if (i == 4) chk("timeout_idle", {126'h0, stall_out, dmem_read}, 128'h0);
        end
        chk("timeout_strobe_cycles", 128'(n_rd), 128'd4);

        // Reset in the middle of a BUSY access
        @(posedge clk); #1;
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        funct3 = 3'b010; addr = 32'h0000_5000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("midreset_outputs", {23'h0, dmem_address, dmem_read, dmem_write, dmem_wmask,
            dmem_wdata, rdata_out, stall_out, done, req_error}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'h9999_9999;
        @(negedge clk);
        chk("late_resp_ignored", {93'h0, rdata_out, done, stall_out, dmem_read}, 128'h0);
        idle(2);
        @(negedge clk);
        chk("late_resp_no_done", {126'h0, done, req_error}, 128'h0);

        chk("scoreboard_drained", 128'(sb_q.size()), 128'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage initiator toward the data memory port: accepts one load or store per pipeline slot from the EX/MEM register and drives the word-aligned dmem request.
- Generates the byte-lane write mask and the lane-shifted store data.
- Stalls the pipeline until `dmem_resp` arrives, then presents the raw read word for the MEM/WB register. Sign/zero extension is done downstream, selected by `regfilemux`.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 1024: BUSY cycles without `dmem_resp` before the access is abandonedFirst; 0 disables the timeout.
- CNT_W, 11: width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM slot holds a memory instruction.
- req_read  in  1  load.
- req_write  in  1  store.
- funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective address (EX/MEM alu_out).
- store_data  in  32  forwarded rs2 value.
- dmem_address  out  32  {addr[31:2],2'b00}.
- dmem_read  out  1  read strobe.
- dmem_write  out  1  write strobe.
- dmem_wmask  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_resp  in  1  memory completion.
- dmem_rdata  in  32  memory read word.
- rdata_out  out  32  latched raw read word.
- stall_out  out  1  freeze IF..MEM pipeline registers.
- done  out  1  one-cycle pulse: access completed.
- req_error  out  1  one-cycle pulse: misaligned, illegal or timeout.

Behaviour:
- Reset (async, any state): state=IDLE; all dmem_* outputs, rdata_out, done, req_error and the counter go to 0. A `dmem_resp` arriving after reset while in IDLE is ignored.
- Request decode:
  - Accept condition in IDLE: req_valid && (req_read ^ req_write).
  - Illegal: req_valid with both req_read and req_write high, or funct3 ∉ {000,001,010,100,101}. Result: no access, req_error pulses next cycle, no stall.
  - Misaligned: h/hu with addr[0]=1, or w with addr[1:0]≠0. Result: no access, req_error pulses next cycle, no stall.
- Mask and data, registered on accept:
  - b/bu: wmask = 4'b0001<<addr[1:0]; wdata = store_data[7:0] shifted to lane addr[1:0].
  - h/hu: wmask = 4'b0011<<{addr[1],1'b0}; wdata = store_data[15:0] shifted to lane addr[1].
  - w: wmask = 4'b1111; wdata = store_data.
  - Loads: wmask = 0 and wdata = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: stall_out is combinational and equals the accept condition for a legal request. On accept, register address, mask and data, raise dmem_read or dmem_write, clear the counter, and go to BUSY.
  - BUSY: stall_out=1 and strobes are held stable. On dmem_resp: latch rdata_out (loads only; stores leave it unchanged), drop the strobes, go to DONE. Otherwise increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without resp: drop the strobes, pulse req_error, go to IDLE.
  - DONE: done=1 and stall_out=0, so the pipeline advances this cycle. The request inputs still show the completed instruction and are ignored. Next state is IDLE.
- Latency: a legal access takes 1 cycle to issue, then N cycles until resp, then 1 DONE cycle. Minimum stall is 2 cycles (resp in the first BUSY cycle).
- Strobes are never asserted in IDLE or DONE. dmem_read and dmem_write are never high together.
- rdata_out holds its value until the next completed load.

Test Plan:
- Load word: lw addr=0x0000_1008, resp after 3 BUSY cycles with rdata=0xDEAD_BEEF → dmem_address=0x1008, dmem_read high for exactly 3 cycles, stall_out high for 4 cycles, done pulses once, rdata_out=0xDEAD_BEEF.
- Store byte: sb addr=0x2003, store_data=0x0000_00A5 → wmask=4'b1000, wdata=0xA500_0000, dmem_address=0x2000; sh addr=0x2002, store_data=0x1234 → wmask=4'b1100, wdata=0x1234_0000.
- Misaligned access: lw addr=0x1001 → no strobe, stall_out=0, req_error pulses once; same check for lh addr=0x1003.
- Back-to-back loads: lw followed by lw, each resp in 1 cycle → two separate accesses, the DONE cycle issues no request, total 6 cycles.
- Timeout: with TIMEOUT_CYCLES=4 and no resp → strobe high for 4 cycles, then req_error, then IDLE with stall_out=0.
- Reset mid-access: rst asserted in BUSY → all outputs 0 immediately; a later dmem_resp is ignored and done stays 0.
